// File: rtl/fft_pkg.sv
// Shared widths and helpers for the DFT datapath stages.
package fft_pkg;

  localparam int IDX_W = 12;

  typedef logic [IDX_W-1:0] idx_t;

  // Shortest transform the index logic supports; shorter requests are raised to this.
  localparam idx_t N_MIN = idx_t'(2);

  // A length of 0 or 1 makes no sense for a modulo counter, so it is clamped to N_MIN.
  function automatic idx_t clamp_n(input idx_t n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

endpackage

// File: rtl/dft_index_counter_if.sv
// Control/index bundle between the DFT control FSM (master) and the index counter (slave).
// Control inputs are plain levels sampled on clk when ce=1; there is no valid/ready
// handshake. The FSM owns ce/clear_n/enables/sample_num, the counter owns the index and
// done outputs. n_r_dbg exposes the latched transform length for observation.
interface dft_index_counter_if;
  import fft_pkg::*;

  logic ce;
  logic clear_n;
  logic count_n_en;
  logic count_k_en;
  idx_t sample_num;

  idx_t n_idx;
  idx_t k_idx;
  idx_t tw_idx;
  logic bin_done;
  logic data_to_cache_loaded;
  logic calc_end;
  idx_t n_r_dbg;

  modport master (
    output ce, clear_n, count_n_en, count_k_en, sample_num,
    input  n_idx, k_idx, tw_idx, bin_done, data_to_cache_loaded, calc_end, n_r_dbg
  );

  modport slave (
    input  ce, clear_n, count_n_en, count_k_en, sample_num,
    output n_idx, k_idx, tw_idx, bin_done, data_to_cache_loaded, calc_end, n_r_dbg
  );

endinterface

// File: rtl/mod_n_add.sv
// Combinational (a + b) mod n for operands already below n.
// The sum is formed one bit wider so a + b never wraps before the compare.
module mod_n_add #(
  parameter int W = fft_pkg::IDX_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] sum
);

  logic [W:0] s_wide;
  logic [W:0] s_sub;

  // Single conditional subtract is enough because a + b < 2n.
  always_comb begin
    s_wide = {1'b0, a} + {1'b0, b};
    s_sub  = s_wide - {1'b0, n};
    sum    = (s_wide >= {1'b0, n}) ? s_sub[W-1:0] : s_wide[W-1:0];
  end

endmodule

// File: rtl/dft_index_counter.sv
// Sample index n, bin index k and twiddle index (n*k mod N) generator for the DFT.
// tw is tracked incrementally (tw += k each step, reset on n wrap) so no multiplier
// is needed and tw stays aligned with n/k in the same cycle.
module dft_index_counter
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  dft_index_counter_if.slave  bus
);

  idx_t n_q,  n_d;
  idx_t k_q,  k_d;
  idx_t tw_q, tw_d;
  idx_t n_r_q, n_r_d;
  logic bin_done_q, bin_done_d;
  logic loaded_q,   loaded_d;
  logic calc_end_q, calc_end_d;

  idx_t n_last;
  idx_t tw_sum;
  logic frozen;
  logic last_n;
  logic last_k;
  logic step;

  mod_n_add #(.W(IDX_W)) u_tw_add (
    .a   (tw_q),
    .b   (k_q),
    .n   (n_r_q),
    .sum (tw_sum)
  );

  // Next-state: length latch, clear, counter step and the done flags.
  always_comb begin
    n_d        = n_q;
    k_d        = k_q;
    tw_d       = tw_q;
    n_r_d      = n_r_q;
    bin_done_d = bin_done_q;
    loaded_d   = loaded_q;
    calc_end_d = calc_end_q;

    n_last = n_r_q - idx_t'(1);
    frozen = loaded_q | calc_end_q;
    last_n = (n_q == n_last);
    last_k = (k_q == n_last);
    step   = bus.count_n_en && !frozen;

    if (bus.ce) begin
      // Length only follows sample_num while idle or clearing, so it is stable mid-pass.
      if (!bus.count_n_en || !bus.clear_n) begin
        n_r_d = clamp_n(bus.sample_num);
      end

      if (!bus.clear_n) begin
        n_d        = '0;
        k_d        = '0;
        tw_d       = '0;
        bin_done_d = 1'b0;
        loaded_d   = 1'b0;
        calc_end_d = 1'b0;
      end else begin
        bin_done_d = 1'b0;
        if (step) begin
          n_d  = last_n ? '0 : n_q + idx_t'(1);
          tw_d = last_n ? '0 : tw_sum;
          if (last_n) begin
            if (bus.count_k_en) begin
              k_d        = last_k ? '0 : k_q + idx_t'(1);
              bin_done_d = 1'b1;
              if (last_k) calc_end_d = 1'b1;
            end else begin
              loaded_d = 1'b1;
            end
          end
        end
        // Done levels drop only once the FSM has withdrawn the matching enable.
        if (!bus.count_n_en) loaded_d   = 1'b0;
        if (!bus.count_k_en) calc_end_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      n_q        <= '0;
      k_q        <= '0;
      tw_q       <= '0;
      n_r_q      <= N_MIN;
      bin_done_q <= 1'b0;
      loaded_q   <= 1'b0;
      calc_end_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      k_q        <= k_d;
      tw_q       <= tw_d;
      n_r_q      <= n_r_d;
      bin_done_q <= bin_done_d;
      loaded_q   <= loaded_d;
      calc_end_q <= calc_end_d;
    end
  end

  assign bus.n_idx                = n_q;
  assign bus.k_idx                = k_q;
  assign bus.tw_idx               = tw_q;
  assign bus.bin_done             = bin_done_q;
  assign bus.data_to_cache_loaded = loaded_q;
  assign bus.calc_end             = calc_end_q;
  assign bus.n_r_dbg              = n_r_q;

endmodule
